// File: rtl/video_pkg.sv
// Shared types and helpers for the video test-pattern source.
package video_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_HBLANK = 2'd2,
    ST_VBLANK = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    PAT_HRAMP   = 2'd0,
    PAT_VRAMP   = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_SOLID   = 2'd3
  } pattern_e;

  // Number of beats that make up one line.
  function automatic int beats_per_line(input int width, input int samples_per_clock);
    return width / samples_per_clock;
  endfunction

  // Width of a counter that must hold values 0..n-1 (never narrower than 1 bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/video_pattern_pixel.sv
// One pixel of the test pattern, computed purely from coordinates and settings.
// The checkerboard uses bit 3 of x and y, so DATA_WIDTH must be at least 4.
module video_pattern_pixel
  import video_pkg::*;
#(
  parameter int CHANNELS   = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0]          x,
  input  logic [DATA_WIDTH-1:0]          y,
  input  pattern_e                       pattern,
  input  logic [CHANNELS*DATA_WIDTH-1:0] fill_color,
  input  logic                           frame_parity,
  output logic [CHANNELS*DATA_WIDTH-1:0] pixel
);

  logic [DATA_WIDTH-1:0] v;

  // Pick the component value for the selected pattern and replicate it per channel.
  always_comb begin
    v     = '0;
    pixel = '0;
    case (pattern)
      PAT_HRAMP: begin
        v     = x;
        pixel = {CHANNELS{v}};
      end
      PAT_VRAMP: begin
        v     = y;
        pixel = {CHANNELS{v}};
      end
      PAT_CHECKER: begin
        v     = (x[3] ^ y[3] ^ frame_parity) ? '1 : '0;
        pixel = {CHANNELS{v}};
      end
      PAT_SOLID: begin
        pixel = fill_color;
      end
      default: begin
        pixel = '0;
      end
    endcase
  end

endmodule

// File: rtl/video_pattern_src.sv
// AXI4-Stream video test-pattern source: fixed-size frames with programmable
// horizontal and vertical blanking, pattern settings latched at frame start.
//
// state   | meaning
// IDLE    | waiting for enable, no output
// ACTIVE  | driving pixel beats (tvalid high)
// HBLANK  | H_GAP idle cycles between lines
// VBLANK  | V_GAP idle cycles after a frame, then restart or stop
module video_pattern_src
  import video_pkg::*;
#(
  parameter int NEW_WIDTH             = 64,
  parameter int NEW_HEIGHT            = 128,
  parameter int MAX_SAMPLES_PER_CLOCK = 4,
  parameter int CHANNELS              = 3,
  parameter int DATA_WIDTH            = 8,
  parameter int H_GAP                 = 4,
  parameter int V_GAP                 = 16
) (
  input  logic                                                s_axis_video_aclk,
  input  logic                                                s_axis_video_aresetn,
  input  logic                                                enable,
  input  logic [1:0]                                          pattern_sel,
  input  logic [DATA_WIDTH*CHANNELS-1:0]                      fill_color,
  output logic [DATA_WIDTH*CHANNELS*MAX_SAMPLES_PER_CLOCK-1:0] VIDEO_IN_tdata,
  output logic                                                VIDEO_IN_tvalid,
  input  logic                                                VIDEO_IN_tready,
  output logic                                                VIDEO_IN_tuser,
  output logic                                                VIDEO_IN_tlast,
  output logic [15:0]                                         frame_count,
  output logic                                                busy
);

  localparam int BPL   = beats_per_line(NEW_WIDTH, MAX_SAMPLES_PER_CLOCK);
  localparam int XW    = cnt_width(BPL);
  localparam int YW    = cnt_width(NEW_HEIGHT);
  localparam int GAP_W = cnt_width((H_GAP > V_GAP) ? H_GAP : V_GAP);
  localparam int PW    = CHANNELS * DATA_WIDTH;

  state_e                state_q, state_d;
  logic [XW-1:0]         x_beat_q, x_beat_d;
  logic [YW-1:0]         y_q, y_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  pattern_e              pat_q, pat_d;
  logic [PW-1:0]         fill_q, fill_d;
  logic [15:0]           frame_count_q, frame_count_d;
  logic                  run_ok_q, run_ok_d;

  logic                  xfer;
  logic                  last_beat;
  logic                  last_line;
  logic                  latch_cfg;
  logic [PW*MAX_SAMPLES_PER_CLOCK-1:0] beat_pix;

  assign xfer      = (state_q == ST_ACTIVE) && VIDEO_IN_tready;
  assign last_beat = (x_beat_q == XW'(BPL - 1));
  assign last_line = (y_q == YW'(NEW_HEIGHT - 1));

  // State and datapath registers; reset returns everything to an empty IDLE.
  always_ff @(posedge s_axis_video_aclk or negedge s_axis_video_aresetn) begin
    if (!s_axis_video_aresetn) begin
      state_q       <= ST_IDLE;
      x_beat_q      <= '0;
      y_q           <= '0;
      gap_cnt_q     <= '0;
      pat_q         <= PAT_HRAMP;
      fill_q        <= '0;
      frame_count_q <= '0;
      run_ok_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_beat_q      <= x_beat_d;
      y_q           <= y_d;
      gap_cnt_q     <= gap_cnt_d;
      pat_q         <= pat_d;
      fill_q        <= fill_d;
      frame_count_q <= frame_count_d;
      run_ok_q      <= run_ok_d;
    end
  end

  // Next-state logic: beat/line stepping, blanking down-counters, config latch.
  // run_ok holds off the first frame for one edge so reset release is clean.
  always_comb begin
    state_d       = state_q;
    x_beat_d      = x_beat_q;
    y_d           = y_q;
    gap_cnt_d     = gap_cnt_q;
    frame_count_d = frame_count_q;
    run_ok_d      = 1'b1;
    latch_cfg     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (enable && run_ok_q) begin
          state_d   = ST_ACTIVE;
          x_beat_d  = '0;
          y_d       = '0;
          latch_cfg = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (xfer) begin
          if (!last_beat) begin
            x_beat_d = x_beat_q + XW'(1);
          end else begin
            x_beat_d = '0;
            if (!last_line) begin
              y_d = y_q + YW'(1);
              if (H_GAP != 0) begin
                state_d   = ST_HBLANK;
                gap_cnt_d = GAP_W'(H_GAP - 1);
              end
            end else begin
              y_d           = '0;
              frame_count_d = frame_count_q + 16'd1;
              if (V_GAP != 0) begin
                state_d   = ST_VBLANK;
                gap_cnt_d = GAP_W'(V_GAP - 1);
              end else if (enable) begin
                latch_cfg = 1'b1;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end
        end
      end
      ST_HBLANK: begin
        if (gap_cnt_q == '0) begin
          state_d = ST_ACTIVE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      ST_VBLANK: begin
        if (gap_cnt_q == '0) begin
          if (enable) begin
            state_d   = ST_ACTIVE;
            latch_cfg = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    pat_d  = latch_cfg ? pattern_e'(pattern_sel) : pat_q;
    fill_d = latch_cfg ? fill_color : fill_q;
  end

  // Sample k is pixel x_beat*N + (N-1-k), so the leftmost pixel lands in the top slice.
  for (genvar k = 0; k < MAX_SAMPLES_PER_CLOCK; k++) begin : g_pix
    logic [DATA_WIDTH-1:0] px_x;
    logic [PW-1:0]         pix;

    assign px_x = DATA_WIDTH'(32'(x_beat_q) * 32'(MAX_SAMPLES_PER_CLOCK)
                              + 32'(MAX_SAMPLES_PER_CLOCK - 1 - k));

    video_pattern_pixel #(
      .CHANNELS   (CHANNELS),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_pix (
      .x            (px_x),
      .y            (DATA_WIDTH'(y_q)),
      .pattern      (pat_q),
      .fill_color   (fill_q),
      .frame_parity (frame_count_q[0]),
      .pixel        (pix)
    );

    assign beat_pix[(k+1)*PW-1 -: PW] = pix;
  end

  // Outputs decode from registered state only, so reset clears them immediately.
  always_comb begin
    VIDEO_IN_tvalid = (state_q == ST_ACTIVE);
    VIDEO_IN_tuser  = VIDEO_IN_tvalid && (x_beat_q == '0) && (y_q == '0);
    VIDEO_IN_tlast  = VIDEO_IN_tvalid && last_beat;
    VIDEO_IN_tdata  = VIDEO_IN_tvalid ? beat_pix : '0;
    busy            = (state_q != ST_IDLE);
    frame_count     = frame_count_q;
  end

endmodule
